fft_peak_bin: RTL

Per-frame dominant-frequency extractor sitting directly upstream of `tone_detection_fsm`. It consumes the streamed FFT output, computes magnitude squared per bin, and tracks the largest bin within a configurable search window. At end of frame it presents the winning bin index on a valid/ready output. The tone detector samples successive bin indices to classify rising, falling or flat pitch.

---
 rtl/tone_pkg.sv | 7 +
 rtl/fft_peak_bin_if.sv | 16 +
 rtl/fft_peak_bin_mag_sq.sv | 37 +++
 rtl/fft_peak_bin.sv | 91 +++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// tone_pkg: shared types and constants for the tone-detection front end
package tone_pkg;
  typedef enum logic [0:0] {SCAN, RESYNC} peak_state_t;
  localparam int FFT_LEN_DEFAULT = 1024;
  localparam int RE_LSB = 0;
  localparam int IM_LSB = 16;
endpackage

// File: rtl/fft_peak_bin_if.sv
// fft_peak_bin_if: FFT input stream and peak result handshake
interface fft_peak_bin_if #(parameter int BIN_W = 10);
  logic [31:0]      fft_tdata;
  logic             fft_tvalid;
  logic             fft_tlast;
  logic [BIN_W-1:0] peak_bin;
  logic [32:0]      peak_mag;
  logic             peak_valid;
  logic             peak_ready;
  logic             frame_err;
  logic             overrun;
  modport master(output fft_tdata, fft_tvalid, fft_tlast, peak_ready,
                 input peak_bin, peak_mag, peak_valid, frame_err, overrun);
  modport slave(input fft_tdata, fft_tvalid, fft_tlast, peak_ready,
                output peak_bin, peak_mag, peak_valid, frame_err, overrun);
endinterface

// File: rtl/fft_peak_bin_mag_sq.sv
// mag_sq: two-stage pipelined re^2 + im^2 with valid/tag sideband
module mag_sq #(
  parameter int TAG_W = 8
) (
  input  logic              clk_in,
  input  logic              rst_in_n,
  input  logic              in_valid,
  input  logic signed [15:0] in_re,
  input  logic signed [15:0] in_im,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  output logic [32:0]       out_mag,
  output logic [TAG_W-1:0]  out_tag
);
  logic             v1;
  logic [31:0]      rr, ii;
  logic [TAG_W-1:0] t1;
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      v1 <= 1'b0;
      rr <= '0;
      ii <= '0;
      t1 <= '0;
      out_valid <= 1'b0;
      out_mag <= '0;
      out_tag <= '0;
    end else begin
      v1 <= in_valid;
      rr <= $unsigned(32'(in_re) * 32'(in_re));
      ii <= $unsigned(32'(in_im) * 32'(in_im));
      t1 <= in_tag;
      out_valid <= v1;
      out_mag <= {1'b0, rr} + {1'b0, ii};
      out_tag <= t1;
    end
  end
endmodule

// File: rtl/fft_peak_bin.sv
// fft_peak_bin: per-frame peak |X|^2 bin search over a window of FFT bins
module fft_peak_bin import tone_pkg::*; #(
  parameter int FFT_LEN = FFT_LEN_DEFAULT,
  parameter int MIN_BIN = 1,
  parameter int MAX_BIN = FFT_LEN / 2 - 1,
  parameter int BIN_W   = $clog2(FFT_LEN)
) (
  input logic clk_in,
  input logic rst_in_n,
  fft_peak_bin_if.slave bus
);
  localparam logic [BIN_W-1:0] LO = BIN_W'(MIN_BIN);
  localparam logic [BIN_W-1:0] HI = BIN_W'(MAX_BIN);
  localparam logic [BIN_W-1:0] LAST = BIN_W'(FFT_LEN - 1);
  localparam int TAG_W = BIN_W + 4;
  peak_state_t      state;
  logic [BIN_W-1:0] cnt, max_bin, cand_bin, s_bin, o_bin;
  logic [32:0]      max_mag, cand_mag, s_mag, o_mag;
  logic [TAG_W-1:0] r_tag, s_tag;
  logic [31:0]      r_data;
  logic             r_valid, s_valid, scan, at_end;
  logic             s_commit, s_err, s_keep, s_clr, hit, commit;
  logic             o_valid, o_err, o_over;
  always_comb begin
    scan = state == SCAN;
    at_end = cnt == LAST;
    {s_bin, s_commit, s_err, s_keep, s_clr} = s_tag;
    hit = s_valid && s_keep && s_mag > max_mag;
    cand_mag = hit ? s_mag : max_mag;
    cand_bin = hit ? s_bin : max_bin;
    commit = s_valid && s_commit;
  end
  // Frame classification happens on entry; the tag carries the verdict down the pipe
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state <= SCAN;
      cnt <= '0;
      r_valid <= 1'b0;
      r_data <= '0;
      r_tag <= '0;
    end else begin
      r_valid <= bus.fft_tvalid;
      if (bus.fft_tvalid) begin
        r_data <= bus.fft_tdata;
        r_tag <= {cnt, scan && bus.fft_tlast && at_end, scan && (bus.fft_tlast ^ at_end),
                  scan && cnt >= LO && cnt <= HI, bus.fft_tlast || (scan && at_end)};
        cnt <= bus.fft_tlast ? '0 : cnt + 1'b1;
        state <= bus.fft_tlast ? SCAN : (scan && at_end) ? RESYNC : state;
      end
    end
  end
  mag_sq #(.TAG_W(TAG_W)) u_mag (
    .clk_in   (clk_in),
    .rst_in_n (rst_in_n),
    .in_valid (r_valid),
    .in_re    (r_data[RE_LSB +: 16]),
    .in_im    (r_data[IM_LSB +: 16]),
    .in_tag   (r_tag),
    .out_valid(s_valid),
    .out_mag  (s_mag),
    .out_tag  (s_tag)
  );
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      max_mag <= '0;
      max_bin <= LO;
      o_bin <= '0;
      o_mag <= '0;
      o_valid <= 1'b0;
      o_err <= 1'b0;
      o_over <= 1'b0;
    end else begin
      o_err <= s_valid && s_err;
      if (s_valid) begin
        max_mag <= s_clr ? '0 : cand_mag;
        max_bin <= s_clr ? LO : cand_bin;
      end
      if (commit) begin
        o_bin <= cand_bin;
        o_mag <= cand_mag;
      end
      o_valid <= commit || (o_valid && !bus.peak_ready);
      if (commit && o_valid && !bus.peak_ready) o_over <= 1'b1;
    end
  end
  assign bus.peak_bin = o_bin;
  assign bus.peak_mag = o_mag;
  assign bus.peak_valid = o_valid;
  assign bus.frame_err = o_err;
  assign bus.overrun = o_over;
endmodule
